// File: rtl/if_id_latch.sv
`default_nettype none
// ============================================================================
// Module      : if_id_latch
// Description : IF/ID pipeline boundary buffer. Two-entry in-order FIFO that
//               carries {next-PC, instruction} from fetch to decode over
//               valid/ready handshakes, with a flush that drops all entries.
//               Optional statistics counters are built when the macro
//               IFID_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_latch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_npc,
    input  logic [WIDTH-1:0] in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_npc,
    output logic [WIDTH-1:0] out_instr,
`ifdef IFID_STATS_EN
    output logic [31:0]      stall_cnt,
    output logic [15:0]      flush_cnt,
`endif
    output logic [1:0]       occupancy
);

    localparam logic [1:0] c_depth = 2'd2;

    logic [WIDTH-1:0] r_npcMem   [2];
    logic [WIDTH-1:0] r_instrMem [2];
    logic             r_rdPtr;
    logic             r_wrPtr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;

    // Handshake qualifiers; ready depends only on registered state, never on out_ready
    always_comb begin
        in_ready  = !rst && (r_count < c_depth);
        out_valid = (r_count != 2'd0);
        w_push    = in_valid && in_ready && !flush;
        w_pop     = out_valid && out_ready && !flush;
        occupancy = r_count;
        out_npc   = out_valid ? r_npcMem[r_rdPtr]   : '0;
        out_instr = out_valid ? r_instrMem[r_rdPtr] : '0;
    end

    // Storage, pointers and occupancy; flush resets bookkeeping but leaves stale data unread
    always_ff @(posedge clk) begin
        if (rst) begin
            r_npcMem[0]   <= '0;
            r_npcMem[1]   <= '0;
            r_instrMem[0] <= '0;
            r_instrMem[1] <= '0;
            r_rdPtr       <= 1'b0;
            r_wrPtr       <= 1'b0;
            r_count       <= 2'd0;
        end else if (flush) begin
            r_rdPtr       <= 1'b0;
            r_wrPtr       <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_npcMem[r_wrPtr]   <= in_npc;
                r_instrMem[r_wrPtr] <= in_instr;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IFID_STATS_EN
    // Saturating stall and flush counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (r_count != 2'd0) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_latch
// Description : Randomized scoreboard bench for if_id_latch. A queue-based
//               FIFO model predicts accepted transfers; a negedge monitor
//               compares the DUT outputs against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_latch;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_npc;
    logic [WIDTH-1:0] in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_npc;
    logic [WIDTH-1:0] out_instr;
    logic [1:0]       occupancy;
`ifdef IFID_STATS_EN
    logic [31:0]      stall_cnt;
    logic [15:0]      flush_cnt;
`endif

    if_id_latch #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_npc    (in_npc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_npc   (out_npc),
        .out_instr (out_instr),
`ifdef IFID_STATS_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected entries in order, {npc, instr}
    logic [63:0] sbQueue[$];
    bit          started = 1'b0;
    int          passCount = 0;
    int          checkCount = 0;
    longint      stallExp = 0;
    longint      flushExp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    // Reference model: a two-deep queue fed by accepted transfers
    always @(posedge clk) begin
        bit doPush;
        bit doPop;
        started = 1'b1;
        if (rst) begin
            sbQueue.delete();
            stallExp = 0;
            flushExp = 0;
        end else begin
            if (sbQueue.size() != 0 && !out_ready && !flush && stallExp < 64'hFFFF_FFFF) stallExp++;
            if (flush && sbQueue.size() != 0 && flushExp < 64'hFFFF) flushExp++;
            if (flush) begin
                sbQueue.delete();
            end else begin
                doPush = in_valid && (sbQueue.size() < 2);
                doPop  = out_ready && (sbQueue.size() > 0);
                if (doPop)  void'(sbQueue.pop_front());
                if (doPush) sbQueue.push_back({in_npc, in_instr});
            end
        end
    end

    // Monitor: compare presented head and status against the model
    always @(negedge clk) begin
        if (started) begin
            check("occupancy", 32'(occupancy), 32'(sbQueue.size()));
            check("in_ready", 32'(in_ready), 32'((!rst) && (sbQueue.size() < 2)));
            check("out_valid", 32'(out_valid), 32'(sbQueue.size() != 0));
            if (sbQueue.size() != 0) begin
                check("out_npc", out_npc, sbQueue[0][63:32]);
                check("out_instr", out_instr, sbQueue[0][31:0]);
            end else begin
                check("out_npc_idle", out_npc, 32'h0);
                check("out_instr_idle", out_instr, 32'h0);
            end
`ifdef IFID_STATS_EN
            check("stall_cnt", stall_cnt, 32'(stallExp));
            check("flush_cnt", 32'(flush_cnt), 32'(flushExp));
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] npc, input logic [31:0] instr,
                        input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_npc    = npc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_npc = '0; in_instr = '0;
        // Reset then idle
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        // Single transfer consumed immediately
        step(1, 32'd1, 32'h8C22_0000, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Fill with decode stalled, third push refused, then drain
        step(1, 32'd4, 32'h0000_0004, 0, 0, 0);
        step(1, 32'd5, 32'h0000_0005, 0, 0, 0);
        step(1, 32'd6, 32'h0000_0006, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Simultaneous push and pop at occupancy 1
        step(1, 32'd16, 32'h0000_0016, 0, 0, 0);
        step(1, 32'd17, 32'h0000_0017, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Flush while full with a same-cycle push
        step(1, 32'd32, 32'h0000_0032, 0, 0, 0);
        step(1, 32'd33, 32'h0000_0033, 0, 0, 0);
        step(1, 32'd64, 32'h0000_0064, 0, 1, 0);
        step(1, 32'd3, 32'h0000_0003, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef IFID_STATS_EN
        // Seven stall cycles followed by one flush of a non-empty buffer
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'd100, 32'h0000_0100, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("stall_cnt_directed", stall_cnt, 32'd7);
        check("flush_cnt_directed", 32'(flush_cnt), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("stall_cnt_reset", stall_cnt, 32'd0);
        check("flush_cnt_reset", 32'(flush_cnt), 32'd0);
        step(0, 0, 0, 0, 0, 0);
`endif
        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, $urandom,
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        step(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
